// File: rtl/conv_kernel_scheduler.sv
// Shares one NxN dot-product unit across NumKernels stored kernels, one kernel per cycle per held window.
// Optional build macro CONV_KERNEL_SCHED_RELU_EN clamps negative sums to zero at issue.
module conv_kernel_scheduler #(
  parameter int N             = 3,
  parameter int BitSize       = 8,
  parameter int KernelBitSize = 1,
  parameter int NumKernels    = 4,
  localparam int KW           = $clog2(NumKernels)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            k_wr_en,
  input  logic [KW-1:0]                   k_wr_idx,
  input  logic [KernelBitSize*N*N-1:0]    k_wr_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [BitSize*N*N-1:0]          in_data,
  output logic [KernelBitSize*N*N-1:0]    dot_kernel,
  output logic [BitSize*N*N-1:0]          dot_data,
  input  logic [BitSize-1:0]              dot_sum,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [BitSize-1:0]              out_sum,
  output logic [KW-1:0]                   out_kidx,
  output logic                            out_last,
  output logic                            busy
);

  localparam int KWidth = KernelBitSize * N * N;
  localparam int DWidth = BitSize * N * N;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [KW-1:0]       kidx_q, kidx_d;
  logic [DWidth-1:0]   win_q, win_d;
  logic [KWidth-1:0]   bank_q [NumKernels];
  logic [KWidth-1:0]   bank_d [NumKernels];
  logic                out_valid_q, out_valid_d;
  logic [BitSize-1:0]  out_sum_q, out_sum_d;
  logic [KW-1:0]       out_kidx_q, out_kidx_d;
  logic                out_last_q, out_last_d;
  logic                issue;
  logic                last_kernel;
  logic [BitSize-1:0]  issue_sum;

`ifdef CONV_KERNEL_SCHED_RELU_EN
  assign issue_sum = dot_sum[BitSize-1] ? '0 : dot_sum;
`else
  assign issue_sum = dot_sum;
`endif

  always_comb begin
    state_d     = state_q;
    kidx_d      = kidx_q;
    win_d       = win_q;
    bank_d      = bank_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_kidx_d  = out_kidx_q;
    out_last_d  = out_last_q;
    in_ready    = (state_q == IDLE) && !reset;
    issue       = (state_q == RUN) && (!out_valid_q || out_ready);
    last_kernel = (kidx_q == KW'(NumKernels - 1));

    // Out-of-range slot indices match no entry and are dropped.
    for (int unsigned i = 0; i < NumKernels; i++) begin
      if (k_wr_en && (k_wr_idx == KW'(i))) begin
        bank_d[i] = k_wr_data;
      end
    end

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          win_d   = in_data;
          kidx_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (issue) begin
          out_sum_d   = issue_sum;
          out_kidx_d  = kidx_q;
          out_last_d  = last_kernel;
          out_valid_d = 1'b1;
          if (last_kernel) begin
            kidx_d  = '0;
            state_d = IDLE;
          end else begin
            kidx_d = kidx_q + KW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (out_valid_q && out_ready && !issue) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      kidx_q      <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_kidx_q  <= '0;
      out_last_q  <= 1'b0;
      for (int unsigned i = 0; i < NumKernels; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      kidx_q      <= kidx_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_kidx_q  <= out_kidx_d;
      out_last_q  <= out_last_d;
      bank_q      <= bank_d;
    end
  end

  assign dot_data   = win_q;
  assign dot_kernel = bank_q[(state_q == RUN) ? kidx_q : '0];
  assign out_valid  = out_valid_q;
  assign out_sum    = out_sum_q;
  assign out_kidx   = out_kidx_q;
  assign out_last   = out_last_q;
  assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_conv_kernel_scheduler.sv
// Randomized and directed bench for conv_kernel_scheduler with a stub dot unit (low-byte add).
module tb_conv_kernel_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        k_wr_en;
  logic [1:0]  k_wr_idx;
  logic [8:0]  k_wr_data;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] in_data;
  logic [8:0]  dot_kernel;
  logic [71:0] dot_data;
  logic [7:0]  dot_sum;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_sum;
  logic [1:0]  out_kidx;
  logic        out_last;
  logic        busy;

  conv_kernel_scheduler #(
    .N(3),
    .BitSize(8),
    .KernelBitSize(1),
    .NumKernels(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .k_wr_en(k_wr_en),
    .k_wr_idx(k_wr_idx),
    .k_wr_data(k_wr_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .dot_kernel(dot_kernel),
    .dot_data(dot_data),
    .dot_sum(dot_sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_kidx(out_kidx),
    .out_last(out_last),
    .busy(busy)
  );

  assign dot_sum = dot_data[7:0] + dot_kernel[7:0];

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [8:0] mbank [4];
  logic [7:0] got_sum [$];
  logic [1:0] got_kidx [$];
  logic       got_last [$];

  always @(posedge clk) begin
    if (!reset && out_valid && out_ready) begin
      got_sum.push_back(out_sum);
      got_kidx.push_back(out_kidx);
      got_last.push_back(out_last);
    end
  end

  function automatic logic [7:0] relu(input logic [7:0] v);
`ifdef CONV_KERNEL_SCHED_RELU_EN
    return v[7] ? 8'h00 : v;
`else
    return v;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_got();
    got_sum.delete();
    got_kidx.delete();
    got_last.delete();
  endtask

  task automatic set_window(input logic [7:0] b0);
    in_data = {32'($urandom()), 32'($urandom()), b0};
  endtask

  task automatic write_bank(input int idx, input logic [8:0] d);
    k_wr_en   = 1'b1;
    k_wr_idx  = 2'(idx);
    k_wr_data = d;
    step();
    k_wr_en   = 1'b0;
    mbank[idx] = d;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; k_wr_en = 1'b0;
    k_wr_idx = '0; k_wr_data = '0;
    set_window(8'h10);
    for (int i = 0; i < 4; i++) mbank[i] = '0;
    repeat (3) begin
      step();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if ({out_sum, out_kidx, out_last} !== 11'h0) begin errors++; $display("FAIL reset_outputs got %h want 0", {out_sum, out_kidx, out_last}); end
    repeat (3) step();
    checks++; if (out_valid !== 1'b0 || got_sum.size() != 0) begin errors++; $display("FAIL reset_no_result got %b/%0d want 0/0", out_valid, got_sum.size()); end
  endtask

  task automatic test_basic();
    for (int k = 0; k < 4; k++) write_bank(k, 9'(k + 1));
    clear_got();
    set_window(8'h10);
    in_valid = 1'b1; out_ready = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_run got %b%b%b want 100", busy, in_ready, out_valid); end
    checks++; if (dot_data !== in_data || dot_kernel !== mbank[0]) begin errors++; $display("FAIL basic_dot got %h/%h want %h/%h", dot_data, dot_kernel, in_data, mbank[0]); end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_sum !== relu(8'(8'h10 + k + 1)) || out_kidx !== 2'(k) || out_last !== (k == 3)) begin
        errors++;
        $display("FAIL basic_result%0d got %b %h %0d %b want 1 %h %0d %b", k, out_valid, out_sum, out_kidx, out_last, relu(8'(8'h10 + k + 1)), k, (k == 3));
      end
      checks++; if (in_ready !== (k == 3)) begin errors++; $display("FAIL basic_in_ready%0d got %b want %b", k, in_ready, (k == 3)); end
    end
    step();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || got_sum.size() != 4) begin errors++; $display("FAIL basic_drain got %b %b %0d want 0 0 4", out_valid, busy, got_sum.size()); end
  endtask

  task automatic test_backpressure();
    clear_got();
    set_window(8'h10);
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    repeat (5) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_sum !== relu(8'h11) || out_kidx !== 2'd0 || busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold got %b %h %0d %b %b want 1 %h 0 1 0", out_valid, out_sum, out_kidx, busy, in_ready, relu(8'h11));
      end
    end
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      step();
      checks++; if (out_sum !== relu(8'(8'h10 + k + 1)) || out_kidx !== 2'(k)) begin errors++; $display("FAIL bp_release%0d got %h %0d want %h %0d", k, out_sum, out_kidx, relu(8'(8'h10 + k + 1)), k); end
    end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", out_valid); end
    checks++;
    if (got_sum.size() != 4) begin
      errors++; $display("FAIL bp_count got %0d want 4", got_sum.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (got_sum[k] !== relu(8'(8'h11 + k)) || got_kidx[k] !== 2'(k)) begin
          errors++; $display("FAIL bp_seq%0d got %h/%0d want %h/%0d", k, got_sum[k], got_kidx[k], relu(8'(8'h11 + k)), k);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int hs [$];
    int cyc = 0;
    int nwin = 0;
    clear_got();
    set_window(8'h10);
    in_valid = 1'b1; out_ready = 1'b1;
    while (nwin < 2 && cyc < 40) begin
      if (in_valid && in_ready) begin hs.push_back(cyc); nwin++; end
      step();
      cyc++;
      if (nwin == 1 && in_data[7:0] == 8'h10) set_window(8'h20);
      if (nwin == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    repeat (8) step();
    checks++;
    if (nwin != 2) begin
      errors++; $display("FAIL b2b_timeout got %0d handshakes want 2", nwin);
    end else if (hs[1] - hs[0] != 5) begin
      errors++; $display("FAIL b2b_spacing got %0d want 5", hs[1] - hs[0]);
    end
    checks++;
    if (got_sum.size() != 8) begin
      errors++; $display("FAIL b2b_count got %0d want 8", got_sum.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        logic [7:0] e;
        e = relu(8'((i < 4 ? 8'h10 : 8'h20) + (i % 4) + 1));
        if (got_sum[i] !== e || got_kidx[i] !== 2'(i % 4)) begin
          errors++; $display("FAIL b2b_seq%0d got %h/%0d want %h/%0d", i, got_sum[i], got_kidx[i], e, i % 4);
        end
      end
    end
  endtask

  task automatic test_mid_write();
    logic [7:0] exp_s [4];
    for (int pass = 0; pass < 2; pass++) begin
      clear_got();
      set_window(8'h10);
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      // the following edge issues kidx 1 together with the bank write
      k_wr_en   = 1'b1;
      k_wr_idx  = (pass == 0) ? 2'd3 : 2'd1;
      k_wr_data = (pass == 0) ? 9'h010 : 9'h0FF;
      step();
      k_wr_en = 1'b0;
      repeat (5) step();
      exp_s[0] = 8'h11; exp_s[1] = 8'h12; exp_s[2] = 8'h13; exp_s[3] = 8'h20;
      checks++;
      if (got_sum.size() != 4) begin
        errors++; $display("FAIL midwr%0d_count got %0d want 4", pass, got_sum.size());
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (got_sum[k] !== relu(exp_s[k])) begin
            errors++; $display("FAIL midwr%0d_k%0d got %h want %h", pass, k, got_sum[k], relu(exp_s[k]));
          end
        end
      end
    end
    write_bank(1, 9'h002);
    write_bank(3, 9'h004);
  endtask

  task automatic test_reset_mid_run();
    clear_got();
    set_window(8'h10);
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_run got %b %b %b want 0 1 0", out_valid, in_ready, busy); end
    for (int i = 0; i < 4; i++) mbank[i] = '0;
    repeat (4) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_run_leftover got %b want 0", out_valid); end
    end
    clear_got();
    set_window(8'h90);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    checks++;
    if (got_sum.size() != 4) begin
      errors++; $display("FAIL rst_run_count got %0d want 4", got_sum.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (got_sum[k] !== relu(8'h90) || got_kidx[k] !== 2'(k) || got_last[k] !== (k == 3)) begin
          errors++; $display("FAIL rst_run_k%0d got %h/%0d/%b want %h/%0d/%b", k, got_sum[k], got_kidx[k], got_last[k], relu(8'h90), k, (k == 3));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_s [$];
    logic [1:0] exp_k [$];
    logic       exp_l [$];
    int         guard;
    logic [7:0] b0;
    clear_got();
    for (int w = 0; w < 16; w++) begin
      if ($urandom_range(1, 0) == 1) write_bank($urandom_range(3, 0), 9'($urandom()));
      repeat ($urandom_range(2, 0)) step();
      b0 = 8'($urandom());
      set_window(b0);
      in_valid = 1'b1;
      if ($urandom_range(1, 0) == 1) begin
        k_wr_en   = 1'b1;
        k_wr_idx  = 2'($urandom_range(3, 0));
        k_wr_data = 9'($urandom());
        mbank[k_wr_idx] = k_wr_data;
      end
      guard = 0;
      while (!in_ready && guard < 20) begin step(); guard++; end
      out_ready = 1'($urandom_range(1, 0));
      step();
      in_valid = 1'b0;
      k_wr_en  = 1'b0;
      for (int k = 0; k < 4; k++) begin
        exp_s.push_back(relu(8'(b0 + mbank[k][7:0])));
        exp_k.push_back(2'(k));
        exp_l.push_back(k == 3);
      end
      guard = 0;
      while (got_sum.size() < exp_s.size() && guard < 200) begin
        out_ready = 1'($urandom_range(1, 0));
        step();
        guard++;
      end
      out_ready = 1'b1;
      checks++;
      if (guard >= 200) begin
        errors++; $display("FAIL rand_timeout window %0d got %0d want %0d", w, got_sum.size(), exp_s.size());
        break;
      end
    end
    checks++;
    if (got_sum.size() != exp_s.size()) begin
      errors++; $display("FAIL rand_count got %0d want %0d", got_sum.size(), exp_s.size());
    end else begin
      for (int i = 0; i < exp_s.size(); i++) begin
        if (got_sum[i] !== exp_s[i] || got_kidx[i] !== exp_k[i] || got_last[i] !== exp_l[i]) begin
          errors++; $display("FAIL rand_seq%0d got %h/%0d/%b want %h/%0d/%b", i, got_sum[i], got_kidx[i], got_last[i], exp_s[i], exp_k[i], exp_l[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_mid_write();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
